// File: rtl/temp_fmt_pkg.sv
// Shared types and ASCII constants for the temperature-to-ASCII framing path.
// Holds the framer state encoding and the double-dabble step count.
package temp_fmt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2
    } state_t;

    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    localparam int BCD_STEPS = 8;

endpackage

// File: rtl/bin2bcd8.sv
// Sequential double-dabble: converts an 8-bit binary value to three BCD digits,
// one shift-add-3 step per cycle, pulsing done on the cycle the digits are final.
module bin2bcd8
    import temp_fmt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // {hundreds, tens, ones, binary}
    logic [19:0] sr;
    logic [2:0]  cnt;
    logic        running;

    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int d = 0; d < 3; d++) begin
            if (a[8 + 4*d +: 4] >= 4'd5) begin
                a[8 + 4*d +: 4] = a[8 + 4*d +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr      <= {12'h000, bin};
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                sr  <= dabble_step(sr);
                cnt <= cnt + 3'd1;
                if (cnt == 3'(BCD_STEPS - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign hundreds = sr[19:16];
    assign tens     = sr[15:12];
    assign ones     = sr[11:8];

endmodule

// File: rtl/temp_ascii_framer.sv
// Captures an 8-bit temperature, converts it to BCD and streams a fixed-width
// ASCII frame (digits, unit, optional CR LF) over a valid/ready byte handshake.
module temp_ascii_framer
    import temp_fmt_pkg::*;
#(
    parameter logic [7:0] UNIT_CHAR     = 8'h43,
    parameter int         SEND_CRLF     = 1,
    parameter int         ZERO_SUPPRESS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] temperature,
    input  logic       data_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam logic [2:0] LAST_IDX = (SEND_CRLF != 0) ? 3'd5 : 3'd3;

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [7:0] tx_data_nxt;
    logic       tx_valid_nxt;
    logic [7:0] drop_nxt;

    logic       bcd_start;
    logic       bcd_done;
    logic [3:0] dig_h, dig_t, dig_o;

    assign bcd_start = (state == IDLE) && data_valid;
    assign busy      = (state != IDLE);

    bin2bcd8 u_bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (bcd_start),
        .bin      (temperature),
        .done     (bcd_done),
        .hundreds (dig_h),
        .tens     (dig_t),
        .ones     (dig_o)
    );

    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [3:0] h,
                                              input logic [3:0] t, input logic [3:0] o);
        logic [7:0] b;
        case (i)
            3'd0:    b = ((ZERO_SUPPRESS != 0) && h == 4'd0) ? SPACE : ZERO + {4'h0, h};
            3'd1:    b = ((ZERO_SUPPRESS != 0) && h == 4'd0 && t == 4'd0) ? SPACE : ZERO + {4'h0, t};
            3'd2:    b = ZERO + {4'h0, o};
            3'd3:    b = UNIT_CHAR;
            3'd4:    b = CR;
            3'd5:    b = LF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        tx_valid_nxt = tx_valid;
        tx_data_nxt  = tx_data;
        drop_nxt     = drop_count;

        case (state)
            IDLE: begin
                if (data_valid) state_nxt = CONVERT;
            end
            CONVERT: begin
                if (bcd_done) begin
                    state_nxt    = SEND;
                    idx_nxt      = 3'd0;
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = frame_byte(3'd0, dig_h, dig_t, dig_o);
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt    = IDLE;
                        idx_nxt      = 3'd0;
                        tx_valid_nxt = 1'b0;
                        tx_data_nxt  = 8'h00;
                    end else begin
                        idx_nxt     = idx + 3'd1;
                        tx_data_nxt = frame_byte(idx + 3'd1, dig_h, dig_t, dig_o);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Samples arriving while a frame is in flight are counted, never queued.
        if (state != IDLE && data_valid && drop_count != 8'hFF) begin
            drop_nxt = drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            drop_count <= 8'h00;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tx_valid   <= tx_valid_nxt;
            tx_data    <= tx_data_nxt;
            drop_count <= drop_nxt;
        end
    end

endmodule
